// File: rtl/stepgen_timed.sv
// Per-axis step/dir generator: accumulates a signed velocity into a fixed-point
// position and emits step pulses that respect direction setup and step high/low times.
module stepgen_timed #(
    parameter int W = 10,
    parameter int F = 11,
    parameter int T = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [F:0]       vel,
    input  logic [T-1:0]     dirtime,
    input  logic [T-1:0]     steptime,
    input  logic [1:0]       tap,
    output logic [W+F-1:0]   pos,
    output logic             step,
    output logic             dir
);

    localparam int PW  = W + F;
    localparam int SBW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE,
        DIRSETUP,
        PULSE_HI,
        PULSE_LO
    } state_t;

    state_t          state_q, state_d;
    logic [T-1:0]    timer_q, timer_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            step_q, step_d;
    logic            dir_q, dir_d;

    logic [PW-1:0]   vel_ext;
    logic [PW-1:0]   nxt;
    logic [SBW-1:0]  sb;
    logic            step_event;
    logic            req_dir;
    logic            expired;

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_sext
            if (gi <= F) begin : g_low
                assign vel_ext[gi] = vel[gi];
            end else begin : g_high
                assign vel_ext[gi] = vel[F];
            end
        end
    endgenerate

    // A step is due whenever the selected position bit toggles on accumulation.
    assign sb         = SBW'(F) - SBW'(tap);
    assign nxt        = pos_q + vel_ext;
    assign step_event = nxt[sb] != pos_q[sb];
    assign req_dir    = ~vel[F];
    assign expired    = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pos_d   = pos_q;
        step_d  = step_q;
        dir_d   = dir_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    pos_d = nxt;
                    if (step_event) begin
                        if (req_dir != dir_q) begin
                            dir_d   = req_dir;
                            timer_d = dirtime;
                            state_d = DIRSETUP;
                        end else begin
                            step_d  = 1'b1;
                            timer_d = steptime;
                            state_d = PULSE_HI;
                        end
                    end
                end
                DIRSETUP: begin
                    if (expired) begin
                        step_d  = 1'b1;
                        timer_d = steptime;
                        state_d = PULSE_HI;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                PULSE_HI: begin
                    if (expired) begin
                        step_d  = 1'b0;
                        timer_d = steptime;
                        state_d = PULSE_LO;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                PULSE_LO: begin
                    if (expired) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pos_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign pos  = pos_q;
    assign step = step_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_stepgen_timed.sv
// Self-checking bench for stepgen_timed: directed scenarios plus randomized traffic
// against a waveform-schedule reference model.
module tb_stepgen_timed;

    localparam int W  = 10;
    localparam int F  = 11;
    localparam int T  = 4;
    localparam int PW = W + F;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [F:0]    vel;
    logic [T-1:0]  dirtime;
    logic [T-1:0]  steptime;
    logic [1:0]    tap;
    logic [PW-1:0] pos;
    logic          step;
    logic          dir;

    int n_pass  = 0;
    int n_total = 0;

    stepgen_timed #(.W(W), .F(F), .T(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .vel      (vel),
        .dirtime  (dirtime),
        .steptime (steptime),
        .tap      (tap),
        .pos      (pos),
        .step     (step),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    // Reference model: while busy, the step level of each upcoming tick is read from
    // a precomputed schedule; only with an empty schedule does a tick accumulate.
    logic [PW-1:0] m_pos;
    logic          m_step;
    logic          m_dir;
    int            m_q[$];
    int            m_events;

    task automatic model_reset();
        m_pos  = '0;
        m_step = 1'b0;
        m_dir  = 1'b0;
        m_q.delete();
    endtask

    task automatic push_pulse();
        repeat (steptime) m_q.push_back(1);
        m_q.push_back(0);
        repeat (int'(steptime) + 1) m_q.push_back(0);
    endtask

    task automatic model_tick();
        int v;
        int sbi;
        int nxt;
        int s;
        logic rd;
        if (m_q.size() > 0) begin
            s = m_q.pop_front();
            m_step = (s != 0);
        end else begin
            v   = int'($signed(vel));
            sbi = F - int'(tap);
            nxt = (int'(m_pos) + v) & ((1 << PW) - 1);
            if (((nxt >> sbi) & 1) != ((int'(m_pos) >> sbi) & 1)) begin
                m_events++;
                rd = (v > 0);
                if (rd != m_dir) begin
                    m_dir  = rd;
                    m_step = 1'b0;
                    repeat (dirtime) m_q.push_back(0);
                    m_q.push_back(1);
                end else begin
                    m_step = 1'b1;
                end
                push_pulse();
            end
            m_pos = PW'(nxt);
        end
    endtask

    task automatic drive(input logic en);
        enable = en;
        @(posedge clk);
        #1;
        if (en) model_tick();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; vel = '0; tap = 2'd0; steptime = '0; dirtime = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({pos, step, dir} !== '0)
            $display("FAIL reset_state: got pos=%h step=%b dir=%b, expected all zero", pos, step, dir);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== '0)
                $display("FAIL vel0_idle tick %0d: got pos=%h step=%b dir=%b, expected all zero", i, pos, step, dir);
            else n_pass++;
        end
        $display("test_reset done");
    endtask

    task automatic test_first_step();
        logic [PW-1:0] e_pos;
        logic e_step, e_dir;
        do_reset();
        vel = 12'd512; tap = 2'd0; steptime = 4'd2; dirtime = 4'd1;
        for (int t = 1; t <= 13; t++) begin
            drive(1'b1);
            e_pos  = (t < 4) ? PW'(t * 512) : ((t <= 12) ? PW'('h800) : PW'('hA00));
            e_step = (t >= 6 && t <= 8);
            e_dir  = (t >= 4);
            n_total++;
            if ({pos, step, dir} !== {e_pos, e_step, e_dir})
                $display("FAIL first_step tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, e_pos, e_step, e_dir);
            else n_pass++;
        end
        $display("test_first_step done");
    endtask

    task automatic test_min_period();
        int hi_len = 0;
        int rises = 0;
        int guard = 0;
        int exp_steps;
        logic prev_step;
        do_reset();
        vel = 12'd2047; tap = 2'd0; steptime = 4'd0; dirtime = 4'd0;
        prev_step = step;
        for (int t = 0; t < 2000 || (m_q.size() > 0 && guard++ < 20); t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL min_period tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
            if (step) begin
                if (!prev_step) rises++;
                hi_len++;
            end else if (prev_step) begin
                n_total++;
                if (hi_len !== 1)
                    $display("FAIL min_period_high_len tick %0d: got %0d ticks, expected 1", t, hi_len);
                else n_pass++;
                hi_len = 0;
            end
            prev_step = step;
        end
        exp_steps = int'(m_pos >> F);
        n_total++;
        if (rises !== exp_steps)
            $display("FAIL min_period_step_count: got %0d steps, expected %0d", rises, exp_steps);
        else n_pass++;
        $display("test_min_period done: %0d steps", rises);
    endtask

    task automatic test_reversal();
        int rises = 0;
        int rises_after = 0;
        int t_fall = -1;
        int t_rise = -1;
        logic prev_step, prev_dir;
        do_reset();
        vel = 12'd256; tap = 2'd0; steptime = 4'd1; dirtime = 4'd2;
        prev_step = step;
        for (int t = 0; t < 2000 && rises < 16; t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL reversal_fwd tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
            if (step && !prev_step) rises++;
            prev_step = step;
        end
        n_total++;
        if (rises !== 16) $display("FAIL reversal_fwd_steps: got %0d, expected 16", rises);
        else n_pass++;
        vel = 12'hF00;
        prev_dir = dir;
        for (int t = 0; t < 500 && t_rise < 0; t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL reversal_rev tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
            if (prev_dir && !dir) begin
                t_fall = t;
                n_total++;
                if (step !== 1'b0) $display("FAIL reversal_step_at_dir_change: got step=%b, expected 0", step);
                else n_pass++;
            end
            if (step && !prev_step) begin
                if (t_fall >= 0) t_rise = t;
                else rises_after++;
            end
            prev_step = step;
            prev_dir = dir;
        end
        n_total++;
        if (rises_after !== 0 || t_fall < 0 || t_rise - t_fall !== int'(dirtime) + 1)
            $display("FAIL reversal_setup: got %0d early steps, dir fall at %0d, step rise at %0d; expected 0 early steps and rise %0d ticks after fall",
                     rises_after, t_fall, t_rise, int'(dirtime) + 1);
        else n_pass++;
        $display("test_reversal done");
    endtask

    task automatic test_wrap();
        int rises = 0;
        int ev0;
        logic prev_step;
        do_reset();
        tap = 2'd3; vel = 12'hF00; steptime = 4'd0; dirtime = 4'd0;
        ev0 = m_events;
        prev_step = step;
        drive(1'b1);
        n_total++;
        if ({pos, step, dir} !== {21'h1FFF00, 1'b1, 1'b0})
            $display("FAIL wrap_backward: got pos=%h step=%b dir=%b, expected pos=1fff00 step=1 dir=0", pos, step, dir);
        else n_pass++;
        if (step && !prev_step) rises++;
        prev_step = step;
        for (int i = 0; i < 10 && m_q.size() > 0; i++) begin
            drive(1'b1);
            prev_step = step;
        end
        vel = 12'd256;
        drive(1'b1);
        n_total++;
        if ({pos, step, dir} !== {21'h000000, 1'b0, 1'b1})
            $display("FAIL wrap_forward: got pos=%h step=%b dir=%b, expected pos=000000 step=0 dir=1", pos, step, dir);
        else n_pass++;
        prev_step = step;
        for (int t = 0; t < 60 || (m_q.size() > 0 && t < 80); t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL wrap_run tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
            if (step && !prev_step) rises++;
            prev_step = step;
        end
        n_total++;
        if (rises !== m_events - ev0)
            $display("FAIL wrap_step_count: got %0d steps, expected %0d", rises, m_events - ev0);
        else n_pass++;
        $display("test_wrap done");
    endtask

    task automatic test_enable_hold();
        int waited = 0;
        do_reset();
        vel = 12'd512; tap = 2'd0; steptime = 4'd3; dirtime = 4'd0;
        while (step !== 1'b1 && waited < 100) begin
            drive(1'b1);
            waited++;
        end
        n_total++;
        if (step !== 1'b1) $display("FAIL hold_reach_pulse: got step=%b after %0d ticks, expected 1", step, waited);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0);
            n_total++;
            if ({pos, step, dir} !== {m_pos, 1'b1, m_dir})
                $display("FAIL hold_no_enable clk %0d: got pos=%h step=%b dir=%b, expected pos=%h step=1 dir=%b",
                         i, pos, step, dir, m_pos, m_dir);
            else n_pass++;
        end
        for (int t = 0; t < 30; t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL hold_resume tick %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
        end
        $display("test_enable_hold done");
    endtask

    task automatic test_reset_mid_pulse();
        int waited = 0;
        do_reset();
        vel = 12'd1024; tap = 2'd0; steptime = 4'd5; dirtime = 4'd0;
        while (step !== 1'b1 && waited < 100) begin
            drive(1'b1);
            waited++;
        end
        drive(1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({pos, step, dir} !== '0)
            $display("FAIL reset_mid_pulse: got pos=%h step=%b dir=%b, expected all zero", pos, step, dir);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        vel = '0;
        for (int t = 0; t < 20; t++) begin
            drive(1'b1);
            n_total++;
            if ({pos, step, dir} !== '0)
                $display("FAIL reset_discard tick %0d: got pos=%h step=%b dir=%b, expected all zero", t, pos, step, dir);
            else n_pass++;
        end
        $display("test_reset_mid_pulse done");
    endtask

    task automatic test_random();
        do_reset();
        vel = 12'($urandom); tap = 2'($urandom); steptime = 4'($urandom_range(0, 4)); dirtime = 4'($urandom_range(0, 4));
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 19) == 0) vel = 12'($urandom);
            if ($urandom_range(0, 49) == 0) tap = 2'($urandom);
            if (m_q.size() == 0 && $urandom_range(0, 29) == 0) begin
                steptime = 4'($urandom_range(0, 6));
                dirtime  = 4'($urandom_range(0, 6));
            end
            drive($urandom_range(0, 3) != 0);
            n_total++;
            if ({pos, step, dir} !== {m_pos, m_step, m_dir})
                $display("FAIL random cycle %0d: got pos=%h step=%b dir=%b, expected pos=%h step=%b dir=%b",
                         t, pos, step, dir, m_pos, m_step, m_dir);
            else n_pass++;
        end
        $display("test_random done: %0d model step events so far", m_events);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_events = 0;
        model_reset();
        test_reset();
        test_first_step();
        test_min_period();
        test_reversal();
        test_wrap();
        test_enable_hold();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
